// File: rtl/ap_pkg.sv
// ap_pkg: shared sizes, state/command/column encodings and clogb2 for the AP job sequencer.
package ap_pkg;
  function automatic int clogb2(input int v);
    int r;
    for (r = 0; v > 0; r++) v = v >> 1;
    return r;
  endfunction
  localparam int WORD_SIZE = 8;
  localparam int CELL_QUANT = 512;
  localparam int ADDR_W = clogb2(CELL_QUANT);
  localparam int RD_LAT = 2;
  localparam int IRQ_GUARD = 2;
  localparam int TIMEOUT_CYC = 4096;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, UNLOAD, DONE} state_t;
  localparam logic [2:0] CMD_OR = 3'd0, CMD_XOR = 3'd1, CMD_AND = 3'd2, CMD_NOT = 3'd3;
  localparam logic [2:0] CMD_ADD = 3'd4, CMD_SUB = 3'd5, CMD_MULT = 3'd6;
  localparam logic [1:0] COL_A = 2'd0, COL_B = 2'd1, COL_C = 2'd2;
endpackage

// File: rtl/ap_rsp_fifo.sv
// ap_rsp_fifo: small synchronous FIFO holding core read data until the host accepts it.
module ap_rsp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 3,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && (count_q != CW'(DEPTH));
    do_pop = pop && (count_q != '0);
    wr_d = do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/ap_job_sequencer.sv
// ap_job_sequencer: loads operands into the AP core, runs it until IRQ, streams column C back.
// Define AP_TIMEOUT_EN to add a RUN watchdog that flags err and abandons the job.
module ap_job_sequencer
  import ap_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           cmd_in,
  input  logic                 dir_in,
  input  logic [ADDR_W-1:0]    last_idx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_data_in,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  output logic [1:0]           ap_sel_col,
  output logic [2:0]           ap_cmd,
  output logic                 ap_op_direction,
  output logic                 ap_sel_internal_col,
  output logic                 ap_mode,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_irq
);
  localparam int CW = $clog2(RD_LAT + 2);
  localparam int GW = $clog2(IRQ_GUARD + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [2:0] cmd_q, cmd_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CW-1:0] fifo_count, inflight;
  logic dir_q, dir_d, issued_q, issued_d, busy_q, done_q, mode_q, beat, is_last;
`ifdef AP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign in_ready = state_q == LOAD_A || state_q == LOAD_B;
  assign beat = in_valid && in_ready;
  assign is_last = idx_q == last_q;
  // Everything issued but not yet popped must fit in the FIFO when it lands.
  assign ap_read_en = state_q == UNLOAD && !issued_q &&
                      ({1'b0, fifo_count} + {1'b0, inflight} < (CW + 1)'(RD_LAT + 1));
  assign ap_write_en = beat;
  assign ap_addr = idx_q;
  assign ap_data_in = beat ? in_data : '0;
  assign ap_sel_col = state_q == UNLOAD ? COL_C : state_q == LOAD_B ? COL_B : COL_A;
  assign ap_cmd = cmd_q;
  assign ap_op_direction = dir_q;
  assign ap_sel_internal_col = 1'b0;
  assign ap_mode = mode_q;
  assign busy = busy_q;
  assign done = done_q;
  assign out_valid = fifo_count != '0;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    cmd_d = cmd_q;
    dir_d = dir_q;
    issued_d = issued_q;
    guard_d = state_q != RUN ? '0 : guard_q + GW'(guard_q != GW'(IRQ_GUARD));
    vld_d = RD_LAT'({vld_q, ap_read_en});
`ifdef AP_TIMEOUT_EN
    err_d = err_q;
    tmo_d = state_q == RUN ? tmo_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_A;
        idx_d = '0;
        last_d = last_idx;
        cmd_d = cmd_in;
        dir_d = dir_in;
`ifdef AP_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      LOAD_A, LOAD_B: if (beat) begin
        idx_d = is_last ? '0 : idx_q + 1'b1;
        if (is_last) state_d = (state_q == LOAD_B || cmd_q == CMD_NOT) ? RUN : LOAD_B;
      end
      // A still-high flag from the previous job must not end this one.
      RUN: if (guard_q == GW'(IRQ_GUARD) && ap_irq) begin
        state_d = UNLOAD;
        issued_d = 1'b0;
      end
      UNLOAD: if (ap_read_en) begin
        idx_d = is_last ? '0 : idx_q + 1'b1;
        issued_d = is_last;
      end else if (issued_q && inflight == '0 && !out_valid) state_d = DONE;
      default: state_d = IDLE;
    endcase
`ifdef AP_TIMEOUT_EN
    if (state_q == RUN && state_d == RUN && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = DONE;
      err_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      last_q <= '0;
      cmd_q <= '0;
      dir_q <= 1'b0;
      issued_q <= 1'b0;
      guard_q <= '0;
      vld_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
`ifdef AP_TIMEOUT_EN
      tmo_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      cmd_q <= cmd_d;
      dir_q <= dir_d;
      issued_q <= issued_d;
      guard_q <= guard_d;
      vld_q <= vld_d;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
      mode_q <= state_d == RUN;
`ifdef AP_TIMEOUT_EN
      tmo_q <= tmo_d;
      err_q <= err_d;
`endif
    end
  end
  ap_rsp_fifo #(.W(WORD_SIZE), .DEPTH(RD_LAT + 1), .CW(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(vld_q[RD_LAT-1]),
    .din(ap_data_out),
    .pop(out_ready),
    .dout(out_data),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_ap_job_sequencer.sv
// tb_ap_job_sequencer: directed bench driving ap_job_sequencer against a behavioural AP core model.
`timescale 1ns/1ps
module tb_ap_job_sequencer;
  import ap_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, dir_in = 0, in_valid = 0, out_ready = 1, ap_irq = 0;
  logic [2:0] cmd_in = 0;
  logic [ADDR_W-1:0] last_idx = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, busy, done, err, ap_write_en, ap_read_en;
  logic ap_op_direction, ap_sel_internal_col, ap_mode;
  logic [7:0] out_data, ap_data_in;
  logic [7:0] ap_data_out = 0;
  logic [7:0] rd_p1 = 0;
  logic [ADDR_W-1:0] ap_addr;
  logic [1:0] ap_sel_col;
  logic [2:0] ap_cmd;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  ap_job_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in), .dir_in(dir_in),
    .last_idx(last_idx), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .ap_addr(ap_addr), .ap_data_in(ap_data_in),
    .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_sel_col(ap_sel_col),
    .ap_cmd(ap_cmd), .ap_op_direction(ap_op_direction),
    .ap_sel_internal_col(ap_sel_internal_col), .ap_mode(ap_mode),
    .ap_data_out(ap_data_out), .ap_irq(ap_irq)
  );
  logic [7:0] col_a [CELL_QUANT];
  logic [7:0] col_b [CELL_QUANT];
  logic [7:0] col_c [CELL_QUANT];
  always @(posedge clk) begin
    if (ap_write_en && ap_sel_col == COL_A) col_a[ap_addr] <= ap_data_in;
    if (ap_write_en && ap_sel_col == COL_B) col_b[ap_addr] <= ap_data_in;
    rd_p1 <= ap_read_en ? col_c[ap_addr] : 8'h00;
    ap_data_out <= rd_p1;
  end
  logic [19:0] wr_log[$];
  logic [7:0] got[$];
  int rd_iss = 0, pops = 0, rd_viol = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (ap_write_en) wr_log.push_back({ap_sel_col, ap_addr, ap_data_in});
    if (ap_read_en && rd_iss - pops >= RD_LAT + 1) rd_viol++;
    if (ap_read_en) rd_iss++;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      pops++;
    end
    if (done) done_cnt++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  function automatic logic [7:0] op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      CMD_OR: op = a | b;
      CMD_XOR: op = a ^ b;
      CMD_AND: op = a & b;
      CMD_NOT: op = ~a;
      CMD_ADD: op = a + b;
      CMD_SUB: op = a - b;
      default: op = a * b;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input logic [2:0] c, input logic [ADDR_W-1:0] last);
    cmd_in = c;
    last_idx = last;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(input logic [7:0] w);
    in_valid = 1;
    in_data = w;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 0;
  endtask
  task automatic wait_mode();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ap_mode) break;
    end
    if (!ap_mode) begin
      tests++; fails++;
      $display("FAIL wait_mode_timeout ap_mode=%0b required 1", ap_mode);
    end
  endtask
  task automatic fire_irq(input logic [2:0] c, input logic [ADDR_W-1:0] last);
    for (int i = 0; i <= int'(last); i++) col_c[i] = op(c, col_a[i], col_b[i]);
    ap_irq = 1;
    tick();
    ap_irq = 0;
  endtask
  task automatic run_and_fire(input logic [2:0] c, input logic [ADDR_W-1:0] last, input int delay, output int drops);
    drops = 0;
    for (int i = 0; i < delay; i++) begin
      tick();
      @(negedge clk);
      if (!ap_mode) drops++;
    end
    fire_irq(c, last);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL wait_done_timeout done=%0b required 1", done);
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    #2;
    tests++;
    if ({busy, done, err, ap_mode, in_ready, out_valid, ap_write_en, ap_read_en} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl got %b required 00000000",
               {busy, done, err, ap_mode, in_ready, out_valid, ap_write_en, ap_read_en});
    end
    tests++;
    if ({ap_addr, ap_sel_col, ap_cmd, ap_op_direction, ap_sel_internal_col, ap_data_in} !== '0) begin
      fails++;
      $display("FAIL reset_core_if addr=%0d sel=%0d cmd=%0d dir=%0b data=%h required all 0",
               ap_addr, ap_sel_col, ap_cmd, ap_op_direction, ap_data_in);
    end
    tick();
    rst_n = 1;
    tick();
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy got %b required 0", busy);
    end
  endtask
  task automatic test_or();
    logic [7:0] a[4] = '{8'h0F, 8'h01, 8'h00, 8'hAA};
    logic [7:0] b[4] = '{8'hF0, 8'h02, 8'h00, 8'h55};
    logic [7:0] e[4] = '{8'hFF, 8'h03, 8'h00, 8'hFF};
    logic [19:0] w;
    int n0 = wr_log.size(), g0 = got.size(), d0 = done_cnt, drops;
    start_job(CMD_OR, 3);
    for (int k = 0; k < 4; k++) send(a[k]);
    for (int k = 0; k < 4; k++) send(b[k]);
    wait_mode();
    run_and_fire(CMD_OR, 3, 19, drops);
    tests++;
    if (drops != 0) begin
      fails++;
      $display("FAIL or_mode_held dropped %0d cycles required 0", drops);
    end
    tests++;
    if (ap_mode !== 1'b0) begin
      fails++;
      $display("FAIL or_mode_after_irq got %b required 0", ap_mode);
    end
    wait_done();
    tick(); tick(); tick();
    tests++;
    if (wr_log.size() - n0 != 8) begin
      fails++;
      $display("FAIL or_write_count got %0d required 8", wr_log.size() - n0);
    end
    for (int k = 0; k < 8 && n0 + k < wr_log.size(); k++) begin
      w = {k < 4 ? COL_A : COL_B, ADDR_W'(k % 4), k < 4 ? a[k] : b[k - 4]};
      tests++;
      if (wr_log[n0 + k] !== w) begin
        fails++;
        $display("FAIL or_write[%0d] got %h required %h", k, wr_log[n0 + k], w);
      end
    end
    tests++;
    if (got.size() - g0 != 4) begin
      fails++;
      $display("FAIL or_out_count got %0d required 4", got.size() - g0);
    end
    for (int k = 0; k < 4 && g0 + k < got.size(); k++) begin
      tests++;
      if (got[g0 + k] !== e[k]) begin
        fails++;
        $display("FAIL or_out[%0d] got %h required %h", k, got[g0 + k], e[k]);
      end
    end
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL or_done_pulses got %0d required 1", done_cnt - d0);
    end
  endtask
  task automatic test_add();
    int g0 = got.size(), drops;
    start_job(CMD_ADD, 0);
    send(8'h03);
    send(8'h05);
    wait_mode();
    run_and_fire(CMD_ADD, 0, 4, drops);
    wait_done();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL add_busy_at_done got %b required 1", busy);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL add_busy_after_done got %b required 0", busy);
    end
    tests++;
    if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'h08) begin
      fails++;
      $display("FAIL add_out count %0d last %h required 1 beat of 08", got.size() - g0, got[got.size() - 1]);
    end
  endtask
  task automatic test_not();
    logic [7:0] e[2] = '{8'hAA, 8'hF0};
    int n0 = wr_log.size(), g0 = got.size(), drops;
    start_job(CMD_NOT, 1);
    send(8'h55);
    send(8'h0F);
    in_valid = 1;
    in_data = 8'h77;
    wait_mode();
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL not_in_ready_in_run got %b required 0", in_ready);
    end
    run_and_fire(CMD_NOT, 1, 5, drops);
    wait_done();
    tick();
    in_valid = 0;
    tests++;
    if (wr_log.size() - n0 != 2) begin
      fails++;
      $display("FAIL not_write_count got %0d required 2", wr_log.size() - n0);
    end
    for (int k = 0; k < 2 && n0 + k < wr_log.size(); k++) begin
      tests++;
      if (wr_log[n0 + k][19:18] !== COL_A) begin
        fails++;
        $display("FAIL not_write_col[%0d] got %0d required 0", k, wr_log[n0 + k][19:18]);
      end
    end
    tests++;
    if (got.size() - g0 != 2) begin
      fails++;
      $display("FAIL not_out_count got %0d required 2", got.size() - g0);
    end
    for (int k = 0; k < 2 && g0 + k < got.size(); k++) begin
      tests++;
      if (got[g0 + k] !== e[k]) begin
        fails++;
        $display("FAIL not_out[%0d] got %h required %h", k, got[g0 + k], e[k]);
      end
    end
  endtask
  task automatic test_guard();
    int g0 = got.size(), drops;
    ap_irq = 1;
    start_job(CMD_OR, 0);
    send(8'h01);
    send(8'h02);
    wait_mode();
    tick();
    @(negedge clk);
    tests++;
    if (ap_mode !== 1'b1) begin
      fails++;
      $display("FAIL guard_run1 ap_mode got %b required 1", ap_mode);
    end
    tick();
    ap_irq = 0;
    @(negedge clk);
    tests++;
    if (ap_mode !== 1'b1) begin
      fails++;
      $display("FAIL guard_run2 ap_mode got %b required 1", ap_mode);
    end
    run_and_fire(CMD_OR, 0, 3, drops);
    tests++;
    if (drops != 0 || ap_mode !== 1'b0) begin
      fails++;
      $display("FAIL guard_late_irq drops %0d ap_mode %b required 0 and 0", drops, ap_mode);
    end
    wait_done();
    tick();
    tests++;
    if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'h03) begin
      fails++;
      $display("FAIL guard_out count %0d last %h required 1 beat of 03", got.size() - g0, got[got.size() - 1]);
    end
  endtask
  task automatic test_backpressure();
    logic [7:0] e[8] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int g0 = got.size(), v0 = rd_viol, drops;
    logic seen = 0;
    start_job(CMD_SUB, 7);
    for (int k = 0; k < 8; k++) send(8'((k + 1) * 16));
    for (int k = 0; k < 8; k++) send(8'(k + 1));
    wait_mode();
    tests++;
    if (ap_cmd !== CMD_SUB) begin
      fails++;
      $display("FAIL bp_cmd_latched got %0d required 5", ap_cmd);
    end
    run_and_fire(CMD_SUB, 7, 4, drops);
    for (int i = 0; i < 200 && !seen; i++) begin
      out_ready = pat[i % 4];
      @(negedge clk);
      seen = done;
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL bp_done_timeout done not seen, required pulse");
    end
    tests++;
    if (got.size() - g0 != 8) begin
      fails++;
      $display("FAIL bp_out_count got %0d required 8", got.size() - g0);
    end
    for (int k = 0; k < 8 && g0 + k < got.size(); k++) begin
      tests++;
      if (got[g0 + k] !== e[k]) begin
        fails++;
        $display("FAIL bp_out[%0d] got %h required %h", k, got[g0 + k], e[k]);
      end
    end
    tests++;
    if (rd_viol != v0) begin
      fails++;
      $display("FAIL bp_read_overcommit got %0d reads with %0d outstanding, required 0", rd_viol - v0, RD_LAT + 1);
    end
  endtask
  task automatic test_reset_mid();
    int g0, drops;
    start_job(CMD_OR, 1);
    for (int k = 0; k < 4; k++) send(8'(k));
    wait_mode();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    tests++;
    if ({ap_mode, busy, out_valid, in_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_async mode/busy/ovalid/iready got %b required 0000", {ap_mode, busy, out_valid, in_ready});
    end
    tick();
    rst_n = 1;
    tick();
    g0 = got.size();
    start_job(CMD_XOR, 0);
    send(8'h5A);
    send(8'hFF);
    wait_mode();
    run_and_fire(CMD_XOR, 0, 3, drops);
    wait_done();
    tick();
    tests++;
    if (got.size() - g0 != 1 || got[got.size() - 1] !== 8'hA5) begin
      fails++;
      $display("FAIL midreset_next_job count %0d last %h required 1 beat of a5", got.size() - g0, got[got.size() - 1]);
    end
  endtask
`ifdef AP_TIMEOUT_EN
  task automatic test_timeout();
    int g0 = got.size(), n = 0;
    start_job(CMD_OR, 0);
    send(8'h01);
    send(8'h02);
    wait_mode();
    while (!done && n < TIMEOUT_CYC + 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != TIMEOUT_CYC || err !== 1'b1 || ap_mode !== 1'b0) begin
      fails++;
      $display("FAIL timeout cycles %0d err %b mode %b required %0d 1 0", n, err, ap_mode, TIMEOUT_CYC);
    end
    tick();
    tests++;
    if (got.size() != g0 || err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_after outputs %0d err %b required 0 and sticky 1", got.size() - g0, err);
    end
    start_job(CMD_OR, 0);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_clear got %b required 0", err);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask
`endif
  initial begin
    test_reset();
    test_or();
    test_add();
    test_not();
    test_guard();
    test_backpressure();
    test_reset_mid();
`ifdef AP_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
